// File: rtl/controlador_bus.sv
// controlador_bus: CPUCR bus initiator; sequences single read/write cycles on Direccion/Datos/LE.
// Define WORD16_EN to enable two-byte little-endian word transfers (size=1).
module controlador_bus (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic        size,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic [15:0] Direccion,
    inout  wire  [7:0]  Datos,
    output logic        LE
);

    typedef enum logic [2:0] {IDLE, RD, WR_SET, WR_STB, DONE} state_t;

    state_t     state;
    logic [7:0] dout;

`ifdef WORD16_EN
    logic       word;
    logic       second;
    logic [7:0] hi_byte;
    logic [7:0] rd_lo;
`else
    logic       unused_inputs;
    assign unused_inputs = ^{size, wdata[15:8]};
`endif

    // Driver follows the registered strobe, so it releases the bus the instant LE rises.
    assign Datos = LE ? 8'bz : dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            Direccion <= 16'h0000;
            LE        <= 1'b1;
            rdata     <= 16'h0000;
            ack       <= 1'b0;
            busy      <= 1'b0;
            dout      <= 8'h00;
`ifdef WORD16_EN
            word      <= 1'b0;
            second    <= 1'b0;
            hi_byte   <= 8'h00;
            rd_lo     <= 8'h00;
`endif
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    LE <= 1'b1;
                    if (req) begin
                        Direccion <= addr;
                        busy      <= 1'b1;
                        dout      <= wdata[7:0];
`ifdef WORD16_EN
                        word      <= size;
                        second    <= 1'b0;
                        hi_byte   <= wdata[15:8];
`endif
                        state     <= we ? WR_SET : RD;
                    end
                end
                RD: begin
`ifdef WORD16_EN
                    if (word && !second) begin
                        // low byte parked until the whole word is in, so rdata only changes at completion
                        rd_lo     <= Datos;
                        second    <= 1'b1;
                        Direccion <= Direccion + 16'd1;
                    end else begin
                        rdata <= second ? {Datos, rd_lo} : {8'h00, Datos};
                        ack   <= 1'b1;
                        state <= DONE;
                    end
`else
                    rdata <= {8'h00, Datos};
                    ack   <= 1'b1;
                    state <= DONE;
`endif
                end
                WR_SET: begin
                    LE    <= 1'b0;
                    state <= WR_STB;
                end
                WR_STB: begin
                    LE <= 1'b1;
`ifdef WORD16_EN
                    if (word && !second) begin
                        second    <= 1'b1;
                        dout      <= hi_byte;
                        Direccion <= Direccion + 16'd1;
                        state     <= WR_SET;
                    end else begin
                        ack   <= 1'b1;
                        state <= DONE;
                    end
`else
                    ack   <= 1'b1;
                    state <= DONE;
`endif
                end
                DONE: begin
                    LE    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    LE    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/controlador_bus.md
# controlador_bus

CPUCR bus initiator: drives the system address bus, the bidirectional 8-bit data bus and the LE strobe toward main memory on behalf of the CPU core. It accepts single read/write requests from the core over a req/ack handshake, sequences the bus cycle, and returns read data. It sits between the CPUCR control unit and main memory and is the only master on the bus.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  core request; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `size`  in  1  0 = byte, 1 = 16-bit word; sampled with `req`, used only with `WORD16_EN`.
- `addr`  in  16  access address; sampled with `req`.
- `wdata`  in  16  write data, low byte in [7:0]; sampled with `req`.
- `rdata`  out  16  read data; valid while `ack`=1 and held until the next read completes.
- `ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from the edge accepting `req` until the edge ending the DONE state.
- `Direccion`  out  16  bus address, registered.
- `Datos`  inout  8  data bus; driven only while `LE`=0, otherwise high-Z.
- `LE`  out  1  1 = read/idle (memory drives `Datos`), 0 = write strobe; memory captures on the falling edge.

## Operation
- States: IDLE, RD, WR_SET, WR_STB, DONE.
- IDLE: `LE`=1, driver off. On `req`=1: latch `we`, `size`, `addr`, `wdata`; load `Direccion`=`addr`; `busy`=1; go to RD if `we`=0, else WR_SET.
- RD: capture `Datos` into the current byte of `rdata` (low byte first). Go to DONE, or for a word's first byte, load `Direccion`+1 and stay in RD for one more cycle.
- WR_SET: `Direccion` stable, `LE`=1, driver off; next go to WR_STB.
- WR_STB: `LE`=0, `Datos`=current byte; lasts exactly one cycle. Then go to DONE; for a word's first byte, load `Direccion`+1 and return to WR_SET with the high byte.
- DONE: `LE`=1, driver off, `ack`=1 for exactly this cycle, `busy`=0 at the following edge. Always go to IDLE. A new request needs `req` sampled in IDLE, so there is no back-to-back issue from DONE.
- `req` outside IDLE is ignored, not queued.
- Word order is little-endian: byte at `addr` → [7:0], byte at `addr`+1 → [15:8].
- Address increment wraps modulo 2^16: 0xFFFF+1 = 0x0000.
- Reset (asynchronous, any state): state IDLE, `Direccion`=0x0000, `LE`=1, `Datos` high-Z, `rdata`=0x0000, `ack`=0, `busy`=0.
- Reset during WR_STB forces `LE` high immediately. The falling edge already issued stands, so that byte is written. No further bytes are written and no `ack` is given.

## Timing
- Edge 0 accepts `req`; `Direccion` is valid after edge 0.
- Byte read: data sampled at edge 1; `ack`=1 in the cycle after edge 1; `rdata` is valid in that same cycle.
- Word read: `ack` in the cycle after edge 2.
- Byte write: `LE` falls after edge 1 and rises after edge 2; `ack` in the cycle after edge 2.
- Word write: the second strobe is low between edges 3 and 4; `ack` in the cycle after edge 4.
- `Direccion` is stable for the whole cycle before and during every `LE`-low cycle.
- `Datos` is never driven while `LE`=1, so there is no contention with the memory.

## Configuration
- `WORD16_EN` defined: `size`=1 performs the two-byte sequences above.
- `WORD16_EN` undefined: `size` is ignored and every access is a single byte.
  - `rdata[15:8]` always reads 0x00.
  - `wdata[15:8]` is unused.
  - The `Direccion`+1 logic is not generated.

## Test plan
- Memory[0x1000]=0x00. Byte read at 0x1000 → `ack` in the cycle after edge 1, `rdata`=0x0000, `LE` stays 1.
- `WORD16_EN`: memory[0x1000]=0x00, [0x1001]=0x20. Word read at 0x1000 → `rdata`=0x2000, `ack` in the cycle after edge 2.
- Byte write 0x09 to 0x3000, then byte read at 0x3000 → reads 0x09. `LE` is low for exactly one cycle and `Datos` is high-Z in all other cycles.
- `WORD16_EN`: word write 0xBEEF to 0xFFFF → memory[0xFFFF]=0xEF, memory[0x0000]=0xBE. Two `LE` pulses; `ack` after edge 4.
- Assert `req` while `busy`=1 with a different address → ignored; only the first transaction completes with a single `ack`.
- Assert `reset_n`=0 during WR_STB → `LE`=1, `Datos` high-Z, `busy`=0, `ack`=0 immediately. After release, state is IDLE and the next read works.
